// File: rtl/bin2bcd_defs.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encodings and the double-dabble adjust threshold.
package bin2bcd_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd4;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit's pre-shift correction: add 3 when the digit exceeds 4,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj
  import bin2bcd_defs::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in > ADJ_THRESH) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Parametrised sequential double-dabble binary-to-BCD converter with
// valid/ready on both sides. Optional lz_mask output under BIN2BCD_LZB_EN.
module bin2bcd_seq
  import bin2bcd_defs::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    bin_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd_data,
  output logic                overflow,
  output logic                busy
`ifdef BIN2BCD_LZB_EN
  ,
  output logic [DIGITS-1:0]   lz_mask
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_acc;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_sticky;
  logic [BCD_W+BIN_W-1:0] shifted;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_in  (bcd_acc[4*g +: 4]),
        .digit_out (bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // The MSB of the adjusted top digit is what falls off on this shift.
  assign shifted = {bcd_adj, bin_reg} << 1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      bin_reg    <= '0;
      bcd_acc    <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bin_reg    <= bin_data;
            bcd_acc    <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_acc    <= shifted[BCD_W+BIN_W-1:BIN_W];
          bin_reg    <= shifted[BIN_W-1:0];
          ovf_sticky <= ovf_sticky | bcd_adj[BCD_W-1];
          if (cnt == LAST_CNT) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bcd_data = bcd_acc;
  assign overflow = ovf_sticky;

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] lz_next;
  logic              seen_nonzero;

  // Scan from the top digit down on the value about to be registered.
  always_comb begin
    lz_next      = '0;
    seen_nonzero = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nonzero = seen_nonzero | (|shifted[BIN_W + 4*i +: 4]);
      lz_next[i]   = seen_nonzero;
    end
    lz_next[0] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lz_mask <= '0;
    end else if (state == SHIFT && cnt == LAST_CNT) begin
      lz_mask <= lz_next;
    end
  end
`else
  // Leading-zero mask not built in this configuration.
`endif

endmodule
